// File: rtl/game_state_manager.sv
// -----------------------------------------------------------------------------
// game_state_manager
//   Game-control stage ahead of the tunnel video controller. Turns debounced
//   player buttons into the game_info_reg control byte, runs the IDLE/PLAY/OVER
//   game FSM from the controller's collision flag, keeps a 4-digit BCD score and
//   issues a restart pulse that clears the controller's sticky collision state.
//
// Ports
//   clock           in   25 MHz pixel clock (only clock)
//   rst             in   asynchronous active-high reset
//   btn_left        in   debounced level, 1 = pressed
//   btn_right       in   debounced level, 1 = pressed
//   btn_start       in   debounced level, rising edge = start/restart request
//   collison_detect in   sticky collision flag from the video controller
//   Pixel_row       in   [9:0] current pixel row
//   Pixel_column    in   [9:0] current pixel column
//   game_info_reg   out  [7:0] {3'b000, level, state[1:0], move[1:0]}
//   score           out  [15:0] 4-digit BCD score
//   game_over       out  1 while in OVER
//   game_rst        out  active-high reset pulse to the downstream controller
// -----------------------------------------------------------------------------
module game_state_manager #(
    parameter int unsigned FRAMES_PER_POINT = 30,
    parameter logic [7:0]  LEVEL_UP_BCD     = 8'h01,
    parameter int unsigned RST_PULSE        = 4
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_start,
    input  logic        collison_detect,
    input  logic [9:0]  Pixel_row,
    input  logic [9:0]  Pixel_column,
    output logic [7:0]  game_info_reg,
    output logic [15:0] score,
    output logic        game_over,
    output logic        game_rst
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_POINT - 32'd1);
    localparam logic [3:0] RST_LOAD   = 4'(RST_PULSE - 32'd1);

    // BCD increment with carry between digits; 9999 saturates instead of wrapping.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v == 16'h9999) begin
            r = v;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4];
                end
            end
        end
        return r;
    endfunction

    state_t      state_r;
    state_t      state_nx_s;
    logic        origin_d_r;
    logic        frame_tick_r;
    logic        start_d_r;
    logic        start_pulse_r;
    logic [7:0]  frame_cnt_r;
    logic [7:0]  frame_cnt_nx_s;
    logic [3:0]  rst_cnt_r;
    logic [15:0] score_nx_s;
    logic [1:0]  move_nx_s;
    logic        level_nx_s;
    logic        load_rst_s;
    logic        at_origin_s;

    assign at_origin_s = (Pixel_row == 10'd0) && (Pixel_column == 10'd0);

    // Frame and start-button edge detectors.
    // start_d_r resets to 1 so a button already held through reset is not a start.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            origin_d_r    <= 1'b0;
            frame_tick_r  <= 1'b0;
            start_d_r     <= 1'b1;
            start_pulse_r <= 1'b0;
        end else begin
            origin_d_r    <= at_origin_s;
            frame_tick_r  <= at_origin_s & ~origin_d_r;
            start_d_r     <= btn_start;
            start_pulse_r <= btn_start & ~start_d_r;
        end
    end

    // Next-state, score, frame counter, move and level decode.
    always_comb begin
        state_nx_s     = state_r;
        score_nx_s     = score;
        frame_cnt_nx_s = frame_cnt_r;
        load_rst_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_pulse_r) begin
                    state_nx_s     = ST_PLAY;
                    score_nx_s     = 16'h0000;
                    frame_cnt_nx_s = 8'd0;
                    load_rst_s     = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                // Collision wins over a same-cycle point: score freezes.
                if (collison_detect) begin
                    state_nx_s = ST_OVER;
                end else if (frame_tick_r) begin
                    if (frame_cnt_r == FRAME_LAST) begin
                        frame_cnt_nx_s = 8'd0;
                        score_nx_s     = bcd_inc(score);
                    end else begin
                        frame_cnt_nx_s = frame_cnt_r + 8'd1;
                    end
                end else begin
                    state_nx_s = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (start_pulse_r) begin
                    state_nx_s = ST_IDLE;
                    load_rst_s = 1'b1;
                end else begin
                    state_nx_s = ST_OVER;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        // Move bits change only at frame start and are forced off outside PLAY.
        if (state_nx_s != ST_PLAY) begin
            move_nx_s = 2'b00;
        end else if (frame_tick_r) begin
            case ({btn_left, btn_right})
                2'b10:   move_nx_s = 2'b10;
                2'b01:   move_nx_s = 2'b01;
                default: move_nx_s = 2'b00;
            endcase
        end else begin
            move_nx_s = game_info_reg[1:0];
        end

        // BCD digits order like binary, so a plain compare works.
        level_nx_s = (score_nx_s[15:8] >= LEVEL_UP_BCD);
    end

    // Game FSM state and all registered outputs.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            score         <= 16'h0000;
            frame_cnt_r   <= 8'd0;
            game_info_reg <= 8'h00;
            game_over     <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            score         <= score_nx_s;
            frame_cnt_r   <= frame_cnt_nx_s;
            game_info_reg <= {3'b000, level_nx_s, state_nx_s, move_nx_s};
            game_over     <= (state_nx_s == ST_OVER);
        end
    end

    // Restart pulse: high for RST_PULSE clocks; a new load restarts the count.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rst_cnt_r <= 4'd0;
            game_rst  <= 1'b0;
        end else if (load_rst_s) begin
            rst_cnt_r <= RST_LOAD;
            game_rst  <= 1'b1;
        end else if (rst_cnt_r != 4'd0) begin
            rst_cnt_r <= rst_cnt_r - 4'd1;
            game_rst  <= 1'b1;
        end else begin
            rst_cnt_r <= 4'd0;
            game_rst  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_game_state_manager.sv
// -----------------------------------------------------------------------------
// tb_game_state_manager
//   Directed self-checking bench. u_dut uses the default 30 frames per point;
//   u_sat uses 1 frame per point so the 9999 saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_game_state_manager;

    logic        clock = 1'b0;
    logic        rst;
    logic        btn_left, btn_right, btn_start, collison_detect;
    logic [9:0]  Pixel_row, Pixel_column;
    logic [7:0]  game_info_reg;
    logic [15:0] score;
    logic        game_over, game_rst;

    logic        sat_start;
    logic [9:0]  sat_row, sat_col;
    logic [7:0]  sat_info;
    logic [15:0] sat_score;
    logic        sat_over, sat_grst;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clock = ~clock;

    game_state_manager #(.FRAMES_PER_POINT(30), .LEVEL_UP_BCD(8'h01), .RST_PULSE(4)) u_dut (
        .clock(clock), .rst(rst),
        .btn_left(btn_left), .btn_right(btn_right), .btn_start(btn_start),
        .collison_detect(collison_detect),
        .Pixel_row(Pixel_row), .Pixel_column(Pixel_column),
        .game_info_reg(game_info_reg), .score(score),
        .game_over(game_over), .game_rst(game_rst)
    );

    game_state_manager #(.FRAMES_PER_POINT(1), .LEVEL_UP_BCD(8'h01), .RST_PULSE(4)) u_sat (
        .clock(clock), .rst(rst),
        .btn_left(1'b0), .btn_right(1'b0), .btn_start(sat_start),
        .collison_detect(1'b0),
        .Pixel_row(sat_row), .Pixel_column(sat_col),
        .game_info_reg(sat_info), .score(sat_score),
        .game_over(sat_over), .game_rst(sat_grst)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One frame: raster at origin for one clock, then elsewhere for one clock.
    task automatic frame(input bit sat);
        if (sat) begin
            sat_row = 10'd0; sat_col = 10'd0;
        end else begin
            Pixel_row = 10'd0; Pixel_column = 10'd0;
        end
        tick();
        if (sat) begin
            sat_row = 10'd5; sat_col = 10'd5;
        end else begin
            Pixel_row = 10'd5; Pixel_column = 10'd5;
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b1; collison_detect = 1'b0;
        Pixel_row = 10'd5; Pixel_column = 10'd5;
        sat_start = 1'b0; sat_row = 10'd5; sat_col = 10'd5;

        // 1. reset with start held
        repeat (3) tick();
        chk("rst_info",  16'(game_info_reg), 16'h0000);
        chk("rst_score", score,              16'h0000);
        chk("rst_over",  16'(game_over),     16'h0000);
        chk("rst_grst",  16'(game_rst),      16'h0000);
        rst = 1'b0;
        repeat (5) tick();
        chk("held_start_info", 16'(game_info_reg), 16'h0000);
        chk("held_start_grst", 16'(game_rst),      16'h0000);
        btn_start = 1'b0;
        repeat (2) tick();

        // 2. start edge, restart pulse length, move bits
        btn_start = 1'b1;
        tick(); tick();
        chk("start_info",  16'(game_info_reg), 16'h0004);
        chk("start_score", score,              16'h0000);
        chk("start_grst",  16'(game_rst),      16'h0001);
        repeat (3) begin
            tick();
            chk("grst_hold", 16'(game_rst), 16'h0001);
        end
        tick();
        chk("grst_end", 16'(game_rst), 16'h0000);
        btn_start = 1'b0;

        btn_left = 1'b1;
        repeat (3) tick();
        chk("move_before_tick", 16'(game_info_reg), 16'h0004);
        frame(1'b0);
        chk("move_left", 16'(game_info_reg), 16'h0006);
        btn_left = 1'b0; btn_right = 1'b1;
        tick();
        chk("move_hold", 16'(game_info_reg), 16'h0006);
        frame(1'b0);
        chk("move_right", 16'(game_info_reg), 16'h0005);
        btn_left = 1'b1;
        frame(1'b0);
        chk("move_both", 16'(game_info_reg), 16'h0004);
        btn_left = 1'b0; btn_right = 1'b0;

        // 3. scoring and BCD carry (3 frames already played)
        repeat (26) frame(1'b0);
        chk("score_29f", score, 16'h0000);
        frame(1'b0);
        chk("score_30f", score, 16'h0001);
        repeat (98 * 30) frame(1'b0);
        chk("score_0099", score, 16'h0099);
        chk("level_0099", 16'(game_info_reg), 16'h0004);
        repeat (30) frame(1'b0);
        chk("score_0100", score, 16'h0100);
        chk("level_0100", 16'(game_info_reg), 16'h0014);

        // collide, restart to IDLE, then start a fresh game
        collison_detect = 1'b1;
        tick();
        collison_detect = 1'b0;
        chk("over_first", 16'(game_over), 16'h0001);
        btn_start = 1'b1;
        tick(); tick();
        btn_start = 1'b0;
        tick();
        btn_start = 1'b1;
        tick(); tick();
        btn_start = 1'b0;
        chk("replay_score", score, 16'h0000);

        // 5. collision on the same clock as the 43rd point
        btn_left = 1'b1;
        repeat (42 * 30 + 29) frame(1'b0);
        chk("pre_coll_score", score,              16'h0042);
        chk("pre_coll_info",  16'(game_info_reg), 16'h0006);
        Pixel_row = 10'd0; Pixel_column = 10'd0;
        tick();
        collison_detect = 1'b1;
        Pixel_row = 10'd5; Pixel_column = 10'd5;
        tick();
        chk("coll_score", score,              16'h0042);
        chk("coll_over",  16'(game_over),     16'h0001);
        chk("coll_info",  16'(game_info_reg), 16'h0008);
        frame(1'b0);
        chk("over_hold_score", score, 16'h0042);
        btn_start = 1'b1;
        tick(); tick();
        chk("restart_over", 16'(game_over),     16'h0000);
        chk("restart_info", 16'(game_info_reg), 16'h0000);
        chk("restart_grst", 16'(game_rst),      16'h0001);
        repeat (3) begin
            tick();
            chk("restart_grst_hold", 16'(game_rst), 16'h0001);
        end
        tick();
        chk("restart_grst_end", 16'(game_rst), 16'h0000);
        chk("idle_score", score, 16'h0042);
        btn_start = 1'b0; collison_detect = 1'b0; btn_left = 1'b0;

        // 6. asynchronous reset mid-pulse and mid-PLAY
        tick();
        btn_start = 1'b1;
        tick(); tick();
        chk("pre_arst_info", 16'(game_info_reg), 16'h0004);
        tick();
        chk("pre_arst_grst", 16'(game_rst), 16'h0001);
        rst = 1'b1;
        #1;
        chk("arst_info",  16'(game_info_reg), 16'h0000);
        chk("arst_score", score,              16'h0000);
        chk("arst_over",  16'(game_over),     16'h0000);
        chk("arst_grst",  16'(game_rst),      16'h0000);
        tick();
        rst = 1'b0;
        btn_start = 1'b0;
        tick();

        // 4. saturation at 9999 (1 frame per point)
        sat_start = 1'b1;
        tick(); tick();
        sat_start = 1'b0;
        chk("sat_start_info", 16'(sat_info), 16'h0004);
        repeat (9998) frame(1'b1);
        chk("sat_9998", sat_score, 16'h9998);
        frame(1'b1);
        chk("sat_9999", sat_score, 16'h9999);
        repeat (60) frame(1'b1);
        chk("sat_hold", sat_score,      16'h9999);
        chk("sat_info", 16'(sat_info),  16'h0014);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
